chunked_serial_adder: RTL and testbench



---
 rtl/chunked_serial_adder_if.sv | 25 ++
 rtl/chunked_serial_adder.sv | 106 ++++++++++
 tb/tb_chunked_serial_adder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/chunked_serial_adder_if.sv
// Request/result bundle for the chunked serial adder: start + operands in, busy/done + sum/flags out.
// The master drives a request; the slave (the adder) answers with a one-cycle done pulse.
interface chunked_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c;
  logic             ovf;

  modport master (
    output start, a, b, c_in,
    input  busy, done, s, c, ovf
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, s, c, ovf
  );
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: WIDTH-bit a+b+c_in, CHUNK bits per clock; done pulses NCH+1 edges after accept.
// No backpressure: start is sampled only in IDLE and ignored while busy, one op per NCH+2 cycles.
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  chunked_serial_adder_if.slave bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             cy_q, cy_d;
  logic             c_q, c_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK:0]   ch_sum;
  logic             cin_msb;
  logic             last_ch;

  always_comb begin
    a_ch    = a_q[int'(idx_q)*CHUNK +: CHUNK];
    b_ch    = b_q[int'(idx_q)*CHUNK +: CHUNK];
    ch_sum  = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, cy_q};
    // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out without a second adder.
    cin_msb = ch_sum[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
    last_ch = (idx_q == IW'(NCH - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          cy_d    = bus.c_in;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[int'(idx_q)*CHUNK +: CHUNK] = ch_sum[CHUNK-1:0];
        cy_d = ch_sum[CHUNK];
        if (last_ch) begin
          c_d     = ch_sum[CHUNK];
          ovf_d   = ch_sum[CHUNK] ^ cin_msb;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == RUN) || (state_q == DONE);
  assign bus.done = (state_q == DONE);
  assign bus.s    = s_q;
  assign bus.c    = c_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed and random-operand bench driving CHUNK=4, 1 and 16 instances in lock-step from one request.
// Sums are checked against a+b+c_in computed here, with signed overflow from operand/result signs.
module tb_chunked_serial_adder;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;

  int n_chk;
  int n_err;

  chunked_serial_adder_if #(.WIDTH(16)) if4 ();
  chunked_serial_adder_if #(.WIDTH(16)) if1 ();
  chunked_serial_adder_if #(.WIDTH(16)) if16 ();

  assign if4.start  = start;
  assign if4.a      = a;
  assign if4.b      = b;
  assign if4.c_in   = c_in;
  assign if1.start  = start;
  assign if1.a      = a;
  assign if1.b      = b;
  assign if1.c_in   = c_in;
  assign if16.start = start;
  assign if16.a     = a;
  assign if16.b     = b;
  assign if16.c_in  = c_in;

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4))  u_add4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  chunked_serial_adder #(.WIDTH(16), .CHUNK(1))  u_add1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) u_add16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One request seen by all three instances; latency, pulse count and result checked on each.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        input bit disturb);
    int d4, d1, d16, p4, p1, p16;
    logic [16:0] sum;
    logic        ovf_exp;
    d4 = 0; d1 = 0; d16 = 0; p4 = 0; p1 = 0; p16 = 0;
    @(negedge clk);
    start = 1'b1; a = av; b = bv; c_in = ci;
    @(posedge clk);
    #1;
    start = 1'b0; a = ~av; b = bv ^ 16'h5A5A; c_in = ~ci;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) chk("busy_after_accept", {31'd0, if4.busy}, 32'd1);
      if (disturb && n == 2) begin
        start = 1'b1; a = 16'hDEAD; b = 16'hBEEF;
      end
      if (n == 3) start = 1'b0;
      if (if4.done) begin p4++; if (d4 == 0) d4 = n; end
      if (if1.done) begin p1++; if (d1 == 0) d1 = n; end
      if (if16.done) begin p16++; if (d16 == 0) d16 = n; end
    end
    sum     = {1'b0, av} + {1'b0, bv} + {16'd0, ci};
    ovf_exp = (av[15] == bv[15]) && (sum[15] != av[15]);
    chk("lat_c4", d4, 5);
    chk("lat_c1", d1, 17);
    chk("lat_c16", d16, 2);
    chk("pulses_c4", p4, 1);
    chk("pulses_c1", p1, 1);
    chk("pulses_c16", p16, 1);
    chk("s_c4", {16'd0, if4.s}, {16'd0, sum[15:0]});
    chk("c_c4", {31'd0, if4.c}, {31'd0, sum[16]});
    chk("ovf_c4", {31'd0, if4.ovf}, {31'd0, ovf_exp});
    chk("s_c1", {16'd0, if1.s}, {16'd0, sum[15:0]});
    chk("c_c1", {31'd0, if1.c}, {31'd0, sum[16]});
    chk("ovf_c1", {31'd0, if1.ovf}, {31'd0, ovf_exp});
    chk("s_c16", {16'd0, if16.s}, {16'd0, sum[15:0]});
    chk("c_c16", {31'd0, if16.c}, {31'd0, sum[16]});
    chk("ovf_c16", {31'd0, if16.ovf}, {31'd0, ovf_exp});
  endtask

  // Directed vectors with hand-computed results: a, b, c_in, s, c, ovf.
  logic [15:0] va  [5] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234};
  logic [15:0] vb  [5] = '{16'h0001, 16'h0000, 16'h0001, 16'h8000, 16'h1111};
  logic        vci [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [15:0] vs  [5] = '{16'h0100, 16'h0000, 16'h8000, 16'h0000, 16'h2345};
  logic        vc  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic        vov [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int cnt;
    int stray;
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    #12;
    chk("rst_busy", {31'd0, if4.busy}, 32'd0);
    chk("rst_done", {31'd0, if4.done}, 32'd0);
    chk("rst_s", {16'd0, if4.s}, 32'd0);
    chk("rst_c", {31'd0, if4.c}, 32'd0);
    chk("rst_ovf", {31'd0, if4.ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", {31'd0, if4.busy}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vci[i], (i == 4));
      chk("dir_s", {16'd0, if4.s}, {16'd0, vs[i]});
      chk("dir_c", {31'd0, if4.c}, {31'd0, vc[i]});
      chk("dir_ovf", {31'd0, if4.ovf}, {31'd0, vov[i]});
      if (i == 2) begin
        // Async reset with no clock edge: 0x8000/ovf=1 must clear at once.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_s", {16'd0, if4.s}, 32'd0);
        chk("arst_ovf", {31'd0, if4.ovf}, 32'd0);
        chk("arst_busy", {31'd0, if4.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    // start held high: a new op every NCH+2 = 6 cycles.
    @(negedge clk);
    start = 1'b1; a = 16'h1234; b = 16'h1111; c_in = 1'b0;
    cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (if4.done) begin
        chk("held_pos", n, 5 + 6 * cnt);
        chk("held_s", {16'd0, if4.s}, 32'h2345);
        cnt++;
      end
    end
    chk("held_count", cnt, 3);
    start = 1'b0;
    repeat (25) @(negedge clk);

    // Abort in the second RUN cycle: no stale done afterwards.
    start = 1'b1; a = 16'h00FF; b = 16'h0001; c_in = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, if4.busy}, 32'd0);
    chk("abort_s", {16'd0, if4.s}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (if4.done || if1.done || if16.done) stray++;
    end
    chk("abort_no_done", stray, 0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    chk("abort_fresh_s", {16'd0, if4.s}, 32'h0002);

    for (int i = 0; i < 1000; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
